// File: rtl/clk_div_monitor_if.sv
// clk_div_monitor_if: monitored divided clock, control pulses and monitor results
interface clk_div_monitor_if #(
  parameter int CW  = 16,
  parameter int ECW = 8
);
  logic           clk_div_in;
  logic           enable;
  logic           err_clr;
  logic           rise_tick;
  logic           fall_tick;
  logic           period_valid;
  logic           locked;
  logic           err;
  logic [CW-1:0]  half_period;
  logic [ECW-1:0] err_count;
  modport master (
    output clk_div_in, enable, err_clr,
    input  rise_tick, fall_tick, period_valid, locked, err, half_period, err_count
  );
  modport slave (
    input  clk_div_in, enable, err_clr,
    output rise_tick, fall_tick, period_valid, locked, err, half_period, err_count
  );
endinterface

// File: rtl/clk_div_monitor.sv
// clk_div_monitor: edge ticks, half-period measurement, lock and error tracking for a divided clock
module clk_div_monitor #(
  parameter int DIV      = 6,
  parameter int TOL      = 0,
  parameter int LOCK_CNT = 4,
  parameter int CW       = 16,
  parameter int ECW      = 8
) (
  input logic               clk,
  input logic               reset,
  clk_div_monitor_if.slave  bus
);
  localparam int GW = $clog2(LOCK_CNT + 1);
  // A half-period one cycle over the window still arrives as a (bad) measurement;
  // only a stall beyond that is treated as a missing edge.
  localparam int TO = DIV + TOL + 2;
  typedef enum logic [1:0] {IDLE, ARM, MEAS, LOCKED} state_t;
  state_t         state_q, state_d;
  logic           s1_q, s2_q, prev_q;
  logic [CW-1:0]  hcnt_q, hcnt_d, half_period_q, half_period_d;
  logic [GW-1:0]  good_q, good_d;
  logic [ECW-1:0] err_count_q, err_count_d;
  logic           rise_q, rise_d, fall_q, fall_d, pv_q, pv_d;
  logic           locked_q, locked_d, err_q, err_d;
  logic           edge_w, active, in_win, err_ev;
  // next-state: edge detect, half-period counter, lock FSM and error bookkeeping
  always_comb begin
    edge_w        = s2_q ^ prev_q;
    active        = state_q == MEAS || state_q == LOCKED;
    in_win        = hcnt_q >= CW'(DIV - TOL) && hcnt_q <= CW'(DIV + TOL);
    err_ev        = bus.enable && active && (edge_w ? !in_win : hcnt_q == CW'(TO));
    rise_d        = s2_q & ~prev_q;
    fall_d        = ~s2_q & prev_q;
    state_d       = state_q;
    hcnt_d        = edge_w ? CW'(1) : (hcnt_q == '1 ? hcnt_q : hcnt_q + CW'(1));
    good_d        = good_q;
    locked_d      = locked_q;
    pv_d          = 1'b0;
    half_period_d = half_period_q;
    if (!bus.enable) begin
      state_d  = IDLE;
      hcnt_d   = '0;
      good_d   = '0;
      locked_d = 1'b0;
    end else if (state_q == IDLE) begin
      state_d = ARM;
      hcnt_d  = '0;
    end else if (state_q == ARM) begin
      state_d = edge_w ? MEAS : ARM;
    end else if (edge_w) begin
      pv_d          = 1'b1;
      half_period_d = hcnt_q;
      if (in_win) begin
        good_d = (good_q >= GW'(LOCK_CNT - 1)) ? GW'(LOCK_CNT) : good_q + GW'(1);
        if (good_q >= GW'(LOCK_CNT - 1)) begin
          locked_d = 1'b1;
          state_d  = LOCKED;
        end
      end else begin
        good_d   = '0;
        locked_d = 1'b0;
        state_d  = MEAS;
      end
    end else if (hcnt_q == CW'(TO)) begin
      good_d   = '0;
      locked_d = 1'b0;
      state_d  = ARM;
    end
    err_d       = err_ev ? 1'b1 : (bus.err_clr ? 1'b0 : err_q);
    err_count_d = err_ev ? (err_count_q == '1 ? err_count_q : err_count_q + ECW'(1))
                         : (bus.err_clr ? '0 : err_count_q);
  end
  // state and registered outputs, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      prev_q        <= 1'b0;
      hcnt_q        <= '0;
      good_q        <= '0;
      half_period_q <= '0;
      err_count_q   <= '0;
      rise_q        <= 1'b0;
      fall_q        <= 1'b0;
      pv_q          <= 1'b0;
      locked_q      <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      s1_q          <= bus.clk_div_in;
      s2_q          <= s1_q;
      prev_q        <= s2_q;
      hcnt_q        <= hcnt_d;
      good_q        <= good_d;
      half_period_q <= half_period_d;
      err_count_q   <= err_count_d;
      rise_q        <= rise_d;
      fall_q        <= fall_d;
      pv_q          <= pv_d;
      locked_q      <= locked_d;
      err_q         <= err_d;
    end
  end
  assign bus.rise_tick    = rise_q;
  assign bus.fall_tick    = fall_q;
  assign bus.period_valid = pv_q;
  assign bus.locked       = locked_q;
  assign bus.err          = err_q;
  assign bus.err_count    = err_count_q;
  assign bus.half_period  = half_period_q;
endmodule

// File: tb/tb_clk_div_monitor.sv
// tb_clk_div_monitor: table rows, corner sequences and random stimulus against a time-based model
module tb_clk_div_monitor;
  localparam int DIV = 6, TOL = 0, LC = 4, CW = 16, ECW = 8;
  localparam int EMAX = (1 << ECW) - 1;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  clk_div_monitor_if #(.CW(CW), .ECW(ECW)) bus();
  clk_div_monitor #(.DIV(DIV), .TOL(TOL), .LOCK_CNT(LC), .CW(CW), .ECW(ECW)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );
  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  bit din = 1'b0, en = 1'b0;
  bit mh1, mh2, mh3;
  int mode, last, good, m_ecnt, m_hp;
  bit m_rise, m_fall, m_pv, m_locked, m_err;
  typedef struct {int hp; int n; bit en; bit clr; bit locked; bit err; int ecnt; int hpo;} row_t;
  row_t rows[9];
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask
  task automatic model_reset();
    mh1 = 0; mh2 = 0; mh3 = 0;
    mode = 0; last = 0; good = 0; m_ecnt = 0; m_hp = 0;
    m_rise = 0; m_fall = 0; m_pv = 0; m_locked = 0; m_err = 0;
  endtask
  // mode 0 idle, 1 waiting for the first edge, 2 measuring; edges timed in absolute cycles
  task automatic model_clk(input bit d, input bit e_n, input bit clr);
    bit e, ev;
    int hp;
    e = mh2 ^ mh3;
    ev = 0;
    m_rise = e && mh2;
    m_fall = e && !mh2;
    m_pv = 0;
    if (!e_n) begin
      mode = 0; m_locked = 0; good = 0;
    end else if (mode == 0) mode = 1;
    else if (mode == 1) begin
      if (e) begin mode = 2; last = cyc; end
    end else if (e) begin
      hp = cyc - last; last = cyc; m_pv = 1; m_hp = hp;
      if (hp >= DIV - TOL && hp <= DIV + TOL) begin
        good = good < LC ? good + 1 : LC;
        if (good == LC) m_locked = 1;
      end else begin
        ev = 1; good = 0; m_locked = 0;
      end
    end else if (cyc - last == DIV + TOL + 2) begin
      ev = 1; good = 0; m_locked = 0; mode = 1;
    end
    if (ev) begin
      m_err = 1;
      if (m_ecnt < EMAX) m_ecnt++;
    end else if (clr) begin
      m_err = 0; m_ecnt = 0;
    end
    mh3 = mh2; mh2 = mh1; mh1 = d;
  endtask
  task automatic step(input bit clr);
    bus.clk_div_in = din; bus.enable = en; bus.err_clr = clr;
    @(posedge clk);
    cyc++;
    model_clk(din, en, clr);
    #1;
    chk("cycle", {bus.rise_tick, bus.fall_tick, bus.period_valid, bus.locked, bus.err, bus.err_count, bus.half_period},
        {m_rise, m_fall, m_pv, m_locked, m_err, ECW'(m_ecnt), CW'(m_hp)});
  endtask
  task automatic half(input int hp);
    din = ~din;
    repeat (hp) step(1'b0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk("async_reset", {bus.rise_tick, bus.fall_tick, bus.period_valid, bus.locked, bus.err, bus.err_count, bus.half_period}, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask
  initial begin
    bit arm, pend, seen;
    int hps[7];
    rows = '{'{6, 5, 1, 0, 1, 0, 0, 6}, '{8, 1, 1, 0, 1, 0, 0, 6}, '{6, 4, 1, 0, 0, 1, 1, 6},
             '{6, 2, 1, 0, 1, 1, 1, 6}, '{20, 1, 1, 0, 0, 1, 2, 6}, '{6, 5, 1, 0, 1, 1, 2, 6},
             '{5, 3, 1, 0, 0, 1, 4, 5}, '{6, 3, 0, 0, 0, 1, 4, 5}, '{6, 1, 1, 1, 0, 0, 0, 5}};
    bus.clk_div_in = 0; bus.enable = 0; bus.err_clr = 0;
    model_reset();
    #1 chk("reset_state", {bus.rise_tick, bus.fall_tick, bus.period_valid, bus.locked, bus.err, bus.err_count, bus.half_period}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    en = 1'b1;
    repeat (3) step(1'b0);
    for (int i = 0; i < 9; i++) begin
      en = rows[i].en;
      repeat (rows[i].n) half(rows[i].hp);
      if (rows[i].clr) step(1'b1);
      chk("row_locked", bus.locked, rows[i].locked);
      chk("row_err", bus.err, rows[i].err);
      chk("row_err_count", bus.err_count, rows[i].ecnt);
      chk("row_half_period", bus.half_period, rows[i].hpo);
    end
    do_reset();
    en = 1'b1; din = 1'b0;
    repeat (3) step(1'b0);
    hps = '{6, 6, 4, 4, 4, 4, 6};
    arm = 1; pend = 0; seen = 0;
    for (int i = 0; i < 7; i++) begin
      din = ~din;
      for (int k = 0; k < hps[i]; k++) begin
        if (pend) begin
          pend = 0;
          step(1'b1);
          chk("lone_clr", {bus.err, bus.err_count}, 9'd0);
        end else if (arm && (mh2 ^ mh3) && mode == 2 && m_ecnt == 3) begin
          arm = 0; pend = 1; seen = 1;
          step(1'b1);
          chk("clr_vs_err", {bus.err, bus.err_count, bus.half_period}, {1'b1, 8'd4, 16'd4});
        end else step(1'b0);
      end
    end
    chk("clr_collision_seen", seen, 1);
    repeat (262) half(4);
    chk("err_count_sat", {bus.err, bus.err_count}, {1'b1, 8'd255});
    repeat (7) half(6);
    chk("locked_before_reset", bus.locked, 1);
    do_reset();
    repeat (8) half(6);
    chk("relock_after_reset", bus.locked, 1);
    for (int i = 0; i < 300; i++) begin
      en = ($urandom_range(0, 19) != 0);
      din = ~din;
      for (int k = ($urandom_range(0, 19) == 0) ? 15 : $urandom_range(2, 9); k > 0; k--)
        step($urandom_range(0, 29) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
